// File: rtl/datapath.sv
// Bus-centric register datapath: special registers, a 16-entry GPR file,
// a 512-word RAM and a single shared 32-bit bus with fixed-priority drivers.
// Operand storage only; arithmetic lives in a later stage fed from Y.
module datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic        pci,
    input  logic        pco,
    input  logic        iri,
    input  logic        iro,
    input  logic [31:0] pc,
    input  logic [31:0] pc_immediate,
    input  logic [31:0] ir,
    input  logic        mari,
    input  logic        maro,
    input  logic        mdri,
    input  logic        mdro,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        opi,
    input  logic        ipi,
    input  logic        ipo,
    input  logic [31:0] input_unit,
    input  logic        ryi,
    input  logic        ryo,
    input  logic        csigno,
    input  logic        gra,
    input  logic        grb,
    input  logic        grc,
    input  logic        rin,
    input  logic        rout,
    input  logic        baout,
    output logic [31:0] bus_out,
    output logic [31:0] out_port
);

    logic [31:0] pc_reg;
    logic [31:0] ir_reg;
    logic [31:0] mar_reg;
    logic [31:0] mdr_reg;
    logic [31:0] y_reg;
    logic [31:0] in_reg;
    logic [31:0] out_reg;
    logic [31:0] gpr [16];

    // Memory has no reset path so its contents survive clear; it relies on
    // the power-up zero state of the target memory.
    logic [31:0] ram [512];

    logic [3:0]  sel_idx;
    logic [31:0] sel_val;
    logic [31:0] csign_val;
    logic [31:0] ram_rd;
    logic [31:0] bus;

    // The reserved ports and the unused upper IR/MAR bits have no function.
    logic unused_bits;
    assign unused_bits = ^{pc, pc_immediate, ir, ir_reg[31:27], mar_reg[31:9]};

    assign csign_val = {{13{ir_reg[18]}}, ir_reg[18:0]};
    assign ram_rd    = ram[mar_reg[8:0]];
    assign sel_val   = gpr[sel_idx];
    assign bus_out   = bus;
    assign out_port  = out_reg;

    // Register-select decode from IR fields; gra wins over grb over grc.
    always_comb begin
        sel_idx = 4'd0;
        if (gra) begin
            sel_idx = ir_reg[26:23];
        end else if (grb) begin
            sel_idx = ir_reg[22:19];
        end else if (grc) begin
            sel_idx = ir_reg[18:15];
        end
    end

    // Shared bus: exactly one source by fixed priority, zero when undriven.
    always_comb begin
        bus = 32'h0;
        if (mdro) begin
            bus = mdr_reg;
        end else if (pco) begin
            bus = pc_reg;
        end else if (iro) begin
            bus = ir_reg;
        end else if (maro) begin
            bus = mar_reg;
        end else if (ryo) begin
            bus = y_reg;
        end else if (ipo) begin
            bus = in_reg;
        end else if (csigno) begin
            bus = csign_val;
        end else if (rout) begin
            bus = sel_val;
        end else if (baout) begin
            // Base-address read treats index 0 as a literal zero base.
            bus = (sel_idx == 4'd0) ? 32'h0 : sel_val;
        end
    end

    // Special-purpose registers; clear dominates every load enable.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            pc_reg  <= 32'h0;
            ir_reg  <= 32'h0;
            mar_reg <= 32'h0;
            mdr_reg <= 32'h0;
            y_reg   <= 32'h0;
            in_reg  <= 32'h0;
            out_reg <= 32'h0;
        end else begin
            if (pci) begin
                pc_reg <= bus;
            end
            if (iri) begin
                ir_reg <= bus;
            end
            if (mari) begin
                mar_reg <= bus;
            end
            if (mdri) begin
                mdr_reg <= mem_read ? ram_rd : bus;
            end
            if (ryi) begin
                y_reg <= bus;
            end
            if (ipi) begin
                in_reg <= input_unit;
            end
            if (opi) begin
                out_reg <= bus;
            end
        end
    end

    // General-purpose register file; R0 is an ordinary writable register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                gpr[i] <= 32'h0;
            end
        end else if (rin) begin
            gpr[sel_idx] <= bus;
        end
    end

    // RAM write takes the MDR value from before the edge, so a same-cycle
    // MDR load does not leak into the stored word.
    always_ff @(posedge clock) begin
        if (mem_write) begin
            ram[mar_reg[8:0]] <= mdr_reg;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: stimulus pushes expected bus/out_port values
// into a queue, a negedge monitor pops and compares them.
module tb_datapath;

    logic        clock;
    logic        clear;
    logic        pci, pco, iri, iro;
    logic [31:0] pc, pc_immediate, ir;
    logic        mari, maro, mdri, mdro, mem_read, mem_write;
    logic        opi, ipi, ipo;
    logic [31:0] input_unit;
    logic        ryi, ryo, csigno, gra, grb, grc, rin, rout, baout;
    logic [31:0] bus_out, out_port;

    typedef struct {
        string       name;
        bit          is_port;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    datapath dut (
        .clock        (clock),
        .clear        (clear),
        .pci          (pci),
        .pco          (pco),
        .iri          (iri),
        .iro          (iro),
        .pc           (pc),
        .pc_immediate (pc_immediate),
        .ir           (ir),
        .mari         (mari),
        .maro         (maro),
        .mdri         (mdri),
        .mdro         (mdro),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .opi          (opi),
        .ipi          (ipi),
        .ipo          (ipo),
        .input_unit   (input_unit),
        .ryi          (ryi),
        .ryo          (ryo),
        .csigno       (csigno),
        .gra          (gra),
        .grb          (grb),
        .grc          (grc),
        .rin          (rin),
        .rout         (rout),
        .baout        (baout),
        .bus_out      (bus_out),
        .out_port     (out_port)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: compare every pending expectation at the falling edge.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = exp_q.pop_front();
            act = e.is_port ? out_port : bus_out;
            n_total++;
            if (act === e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %08h expected %08h", e.name, act, e.val);
            end
        end
    end

    task automatic idle();
        pci = 0; pco = 0; iri = 0; iro = 0;
        mari = 0; maro = 0; mdri = 0; mdro = 0; mem_read = 0; mem_write = 0;
        opi = 0; ipi = 0; ipo = 0;
        ryi = 0; ryo = 0; csigno = 0; gra = 0; grb = 0; grc = 0;
        rin = 0; rout = 0; baout = 0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic exp_bus(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name; e.is_port = 1'b0; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic exp_port(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name; e.is_port = 1'b1; e.val = v;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        pc = 32'hA5A5A5A5; pc_immediate = 32'h5A5A5A5A; ir = 32'hFFFFFFFF;
        idle();
        input_unit = 32'h0;
        clear = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        exp_bus("rst_bus", 32'h0);
        exp_port("rst_port", 32'h0);
        cyc(); pco = 1; exp_bus("rst_pc", 32'h0);
        cyc(); rout = 1; exp_bus("rst_r0", 32'h0);

        // IN -> Y -> OUT
        cyc(); input_unit = 32'h12345678; ipi = 1;
        cyc(); ipo = 1; ryi = 1; exp_bus("ipo", 32'h12345678);
        cyc(); ryo = 1; opi = 1; exp_bus("ryo", 32'h12345678);
        cyc(); exp_port("opi_port", 32'h12345678); exp_bus("idle_bus", 32'h0);

        // RAM write then read back through MDR
        input_unit = 32'h5; ipi = 1;
        cyc(); ipo = 1; mari = 1;
        cyc(); input_unit = 32'hDEADBEEF; ipi = 1;
        cyc(); ipo = 1; mdri = 1;
        cyc(); mem_write = 1; maro = 1; exp_bus("mar", 32'h5);
        cyc(); mdri = 1;
        cyc(); mdro = 1; exp_bus("mdr_zero", 32'h0);
        cyc(); mem_read = 1; mdri = 1;
        cyc(); mdro = 1; exp_bus("mdr_ram", 32'hDEADBEEF);

        // Simultaneous mem_write and mdri stores the old MDR
        cyc(); input_unit = 32'h6; ipi = 1;
        cyc(); ipo = 1; mari = 1;
        cyc(); input_unit = 32'h11111111; ipi = 1;
        cyc(); ipo = 1; mdri = 1; mem_write = 1;
        cyc(); mdro = 1; exp_bus("mdr_bus_ld", 32'h11111111);
        cyc(); mem_read = 1; mdri = 1;
        cyc(); mdro = 1; exp_bus("wr_pre_edge", 32'hDEADBEEF);

        // Sign-extended constant and register select
        cyc(); input_unit = 32'h00800065; ipi = 1;
        cyc(); ipo = 1; iri = 1;
        cyc(); csigno = 1; exp_bus("csign_pos", 32'h00000065);
        cyc(); csigno = 1; gra = 1; rin = 1;
        cyc(); gra = 1; rout = 1; exp_bus("r1", 32'h00000065);
        cyc(); iro = 1; exp_bus("ir", 32'h00800065);
        cyc(); input_unit = 32'h00840000; ipi = 1;
        cyc(); ipo = 1; iri = 1;
        cyc(); csigno = 1; exp_bus("csign_neg", 32'hFFFC0000);

        // R0 via rout vs baout, grc field, select priority
        cyc(); input_unit = 32'h55; ipi = 1;
        cyc(); ipo = 1; rin = 1;
        cyc(); grb = 1; rout = 1; exp_bus("r0_rout", 32'h55);
        cyc(); grb = 1; baout = 1; exp_bus("r0_baout", 32'h0);
        cyc(); gra = 1; baout = 1; exp_bus("r1_baout", 32'h65);
        cyc(); input_unit = 32'hABCD; ipi = 1;
        cyc(); ipo = 1; grc = 1; rin = 1;
        cyc(); grc = 1; rout = 1; exp_bus("r8", 32'hABCD);
        cyc(); gra = 1; grc = 1; rout = 1; exp_bus("gra_prio", 32'h65);
        cyc(); rout = 1; exp_bus("nosel_r0", 32'h55);

        // Bus priority
        cyc(); ipo = 1; pci = 1;
        cyc(); ryo = 1; mdro = 1; exp_bus("mdro_ryo", 32'hDEADBEEF);
        cyc(); pco = 1; iro = 1; maro = 1; exp_bus("pco_prio", 32'hABCD);
        cyc(); iro = 1; maro = 1; ryo = 1; exp_bus("iro_prio", 32'h00840000);
        cyc(); ryo = 1; ipo = 1; csigno = 1; exp_bus("ryo_prio", 32'h12345678);
        cyc(); csigno = 1; rout = 1; baout = 1; exp_bus("csigno_prio", 32'hFFFC0000);
        cyc(); rout = 1; baout = 1; exp_bus("rout_prio", 32'h55);
        cyc(); exp_bus("no_driver", 32'h0);

        // clear held across an edge overrides every load enable
        cyc(); input_unit = 32'hFFFFFFFF; ipi = 1; ipo = 1; opi = 1; pci = 1;
        iri = 1; mari = 1; ryi = 1; rin = 1; clear = 1;
        @(posedge clock);
        #3;
        clear = 0;
        idle();
        ipo = 1;
        exp_bus("ovr_in", 32'h0);
        exp_port("ovr_port", 32'h0);

        // Mid-cycle clear pulse acts without a clock edge
        cyc(); input_unit = 32'h77; ipi = 1;
        cyc(); ipo = 1; opi = 1; pci = 1;
        cyc(); #1; clear = 1; #1; clear = 0;
        exp_port("async_port", 32'h0);
        pco = 1; exp_bus("async_pc", 32'h0);
        cyc(); iro = 1; exp_bus("clr_ir", 32'h0);
        cyc(); maro = 1; exp_bus("clr_mar", 32'h0);
        cyc(); mdro = 1; exp_bus("clr_mdr", 32'h0);
        cyc(); ryo = 1; exp_bus("clr_y", 32'h0);
        cyc(); rout = 1; exp_bus("clr_r0", 32'h0);

        // RAM contents survive clear
        cyc(); input_unit = 32'h5; ipi = 1;
        cyc(); ipo = 1; mari = 1;
        cyc(); mem_read = 1; mdri = 1;
        cyc(); mdro = 1; exp_bus("ram_keep", 32'hDEADBEEF);
        cyc();

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(negedge clock);
            wait_cnt++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clock  in  1  single system clock; all state updates on rising edge.
REQ-002 clear  in  1  reset, asynchronous, active-high.
REQ-003 pci  in  1  PC load from bus.
REQ-004 pco  in  1  PC drives bus.
REQ-005 iri  in  1  IR load from bus.
REQ-006 iro  in  1  IR drives bus.
REQ-007 pc  in  32  reserved; no functional effect.
REQ-008 pc_immediate  in  32  reserved; no functional effect.
REQ-009 ir  in  32  reserved; no functional effect.
REQ-010 mari  in  1  MAR load from bus.
REQ-011 maro  in  1  MAR drives bus.
REQ-012 mdri  in  1  MDR load enable.
REQ-013 mdro  in  1  MDR drives bus.
REQ-014 mem_read  in  1  MDR input source is RAM[MAR], not bus.
REQ-015 mem_write  in  1  write MDR to RAM[MAR].
REQ-016 opi  in  1  output-port register load from bus.
REQ-017 ipi  in  1  input-port register load from input_unit.
REQ-018 ipo  in  1  input-port register drives bus.
REQ-019 input_unit  in  32  external input data.
REQ-020 ryi / ryo  in  1 each  Y register load from bus / Y drives bus.
REQ-021 csigno  in  1  sign-extended IR constant drives bus.
REQ-022 gra / grb / grc  in  1 each  register-select field choice.
REQ-023 rin / rout / baout  in  1 each  selected-register write / read / base-address read.
REQ-024 bus_out  out  32  current bus value.
REQ-025 out_port  out  32  output-port register.

Function
REQ-026 State registers SHALL be 32-bit: PC, IR, MAR, MDR, Y, IN, OUT, R0-R15.
REQ-027 Each register SHALL load on a rising edge when its enable is high at that edge; otherwise hold.
REQ-028 Bus SHALL be combinational with one driver by fixed priority: mdro > pco > iro > maro > ryo > ipo > csigno > rout > baout.
REQ-029 With no driver asserted, bus SHALL be 0.
REQ-030 Register select SHALL be: gra -> IR[26:23], grb -> IR[22:19], grc -> IR[18:15], priority gra > grb > grc; none asserted -> index 0.
REQ-031 rin SHALL write bus into selected Rn; R0 is writable.
REQ-032 rout SHALL drive selected Rn.
REQ-033 baout SHALL drive selected Rn, except 0 when the index is 0.
REQ-034 csigno SHALL drive {13{IR[18]}, IR[18:0]}.
REQ-035 RAM SHALL be 512x32, addressed by MAR[8:0], with combinational read and all words 0 at time zero.
REQ-036 mem_write SHALL write MDR to RAM[MAR[8:0]] at the rising edge.
REQ-037 If mem_write and mdri are both high, the write SHALL use the pre-edge MDR value.
REQ-038 On mdri, MDR SHALL load RAM[MAR[8:0]] if mem_read=1, else bus.
REQ-039 ipi SHALL load IN from input_unit.
REQ-040 opi SHALL load OUT from bus.
REQ-041 The block SHALL contain no ALU; Y holds operands for a later stage.

Reset
REQ-042 clear=1 SHALL immediately zero all registers (PC, IR, MAR, MDR, Y, IN, OUT, R0-R15), independent of clock.
REQ-043 Reset SHALL override any simultaneous load enable.
REQ-044 RAM contents SHALL be unaffected by clear.

Verification
REQ-045 Pulse clear mid-cycle with no drivers -> bus_out=0, out_port=0, all registers 0.
REQ-046 input_unit=0x12345678; ipi; then ipo+ryi; then ryo+opi -> bus_out=0x12345678, out_port=0x12345678.
REQ-047 Via IN: 0x5 -> MAR, 0xDEADBEEF -> MDR; mem_write; reload MDR=0; mem_read+mdri -> MDR=0xDEADBEEF (check with mdro).
REQ-048 IR=0x00800065: csigno -> bus 0x00000065; csigno+gra+rin -> R1=0x65; gra+rout -> bus 0x65. Then IR=0x00840000: csigno -> 0xFFFC0000.
REQ-049 R0=0x55 with IR[22:19]=0: grb+rout -> 0x55; grb+baout -> 0x00000000.
REQ-050 Drive ryo and mdro together -> bus shows MDR; no drivers -> bus 0.
